// File: rtl/hclk_seq.sv
// Fast-domain clock supervisor: synchronises PLL lock, sequences the domain
// reset and generates phase-aligned programmable clock-enable pulses.
module hclk_seq #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_lock,
  input  logic [CHANNELS*DIV_W-1:0] i_div,
  input  logic                      i_div_load,
  output logic                      o_rst,
  output logic                      o_ready,
  output logic [CHANNELS-1:0]       o_ce,
  output logic [CNT_W-1:0]          o_loss_cnt
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SET_W-1:0] settle_cnt, settle_nx;
  logic             rst_nx, ready_nx;
  logic [CNT_W-1:0] loss_nx;
  logic             lock_m, lock_s;
  logic             run;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= i_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      o_rst      <= 1'b1;
      o_ready    <= 1'b0;
      o_loss_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      o_rst      <= rst_nx;
      o_ready    <= ready_nx;
      o_loss_cnt <= loss_nx;
    end
  end

  // Outputs are computed for the next state so they change on the transition edge
  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    rst_nx    = o_rst;
    ready_nx  = o_ready;
    loss_nx   = o_loss_cnt;
    case (state)
      WAIT_LOCK: begin
        rst_nx    = 1'b1;
        ready_nx  = 1'b0;
        settle_nx = '0;
        if (lock_s) state_nx = SETTLE;
      end
      SETTLE: begin
        rst_nx   = 1'b1;
        ready_nx = 1'b0;
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (settle_cnt == SET_LAST) begin
          state_nx = RUN;
          rst_nx   = 1'b0;
          ready_nx = 1'b1;
        end else begin
          settle_nx = settle_cnt + SET_W'(1);
        end
      end
      RUN: begin
        rst_nx   = 1'b0;
        ready_nx = 1'b1;
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          rst_nx   = 1'b1;
          ready_nx = 1'b0;
          if (o_loss_cnt != {CNT_W{1'b1}}) loss_nx = o_loss_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
        rst_nx   = 1'b1;
        ready_nx = 1'b0;
      end
    endcase
  end

  assign run = (state == RUN);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DIV_W-1:0] shadow, active, cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)           shadow <= DIV_W'(1);
      else if (i_div_load) shadow <= i_div[k*DIV_W +: DIV_W];
    end

    // Counter held at 0 outside RUN so every channel starts aligned;
    // the active divisor only changes on a period boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        active <= DIV_W'(1);
        cnt    <= '0;
      end else if (!run || active == '0) begin
        active <= shadow;
        cnt    <= '0;
      end else if (cnt == active - DIV_W'(1)) begin
        active <= shadow;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end

    assign o_ce[k] = run && (active != '0) && (cnt == '0);
  end

endmodule

// File: tb/tb_hclk_seq.sv
// Scoreboard bench for hclk_seq: expected per-cycle outputs are queued when
// stimulus is applied and compared on the falling edge.
module tb_hclk_seq;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned SC = 8;
  localparam int unsigned CW = 8;

  logic               i_clk;
  logic               i_rst;
  logic               i_lock;
  logic [CH*DW-1:0]   i_div;
  logic               i_div_load;
  logic               o_rst;
  logic               o_ready;
  logic [CH-1:0]      o_ce;
  logic [CW-1:0]      o_loss_cnt;

  hclk_seq #(.CHANNELS(CH), .DIV_W(DW), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lock(i_lock), .i_div(i_div),
    .i_div_load(i_div_load), .o_rst(o_rst), .o_ready(o_ready),
    .o_ce(o_ce), .o_loss_cnt(o_loss_cnt)
  );

  typedef struct {
    int            cyc;
    logic [CH-1:0] ce;
    logic          rst;
    logic          ready;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [CH-1:0] ce, input logic r, input logic rd);
    exp_t e;
    e.cyc = c; e.ce = ce; e.rst = r; e.ready = rd;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int from, input int to);
    for (int c = from; c <= to; c++) push(c, '0, 1'b1, 1'b0);
  endtask

  // Running domain: channel pulses every d cycles counted from reference r0
  task automatic push_run(input int from, input int n, input int r0, input int d0, input int d1);
    logic [CH-1:0] ce;
    for (int c = from; c < from + n; c++) begin
      ce[0] = (d0 != 0) && ((c - r0) % d0 == 0);
      ce[1] = (d1 != 0) && ((c - r0) % d1 == 0);
      push(c, ce, 1'b0, 1'b1);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  always @(negedge i_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      check("sb_late", cur.cyc, cyc);
      check($sformatf("ce@%0d", cur.cyc), 32'(o_ce), 32'(cur.ce));
      check($sformatf("rst@%0d", cur.cyc), 32'(o_rst), 32'(cur.rst));
      check($sformatf("ready@%0d", cur.cyc), 32'(o_ready), 32'(cur.ready));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, m, r, c0;
    logic [CH-1:0] ce;
    i_rst = 1'b1; i_lock = 1'b0; i_div = {8'd1, 8'd1}; i_div_load = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_rst", 32'(o_rst), 1);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_ce", 32'(o_ce), 0);
    check("rst_loss", 32'(o_loss_cnt), 0);
    i_rst = 1'b0;
    wait_cyc(cyc + 2);

    // Lock release timing with default divisors
    n = cyc; i_lock = 1'b1;
    push_idle(n + 1, n + 10);
    push_run(n + 11, 4, n + 11, 1, 1);
    r = n + 11;
    wait_cyc(n + 15);

    // Lock loss in RUN: reset three cycles after the raw drop
    m = cyc; i_lock = 1'b0;
    push_run(m + 1, 2, r, 1, 1);
    push_idle(m + 3, m + 5);
    wait_cyc(m + 5);
    check("loss_one", 32'(o_loss_cnt), 1);

    // Divisors 5/3 loaded while waiting for lock
    i_div = {8'd3, 8'd5}; i_div_load = 1'b1;
    wait_cyc(cyc + 1);
    i_div_load = 1'b0;
    wait_cyc(cyc + 2);
    n = cyc; i_lock = 1'b1; r = n + 11;
    push_idle(n + 1, n + 10);
    push_run(r, 16, r, 5, 3);
    wait_cyc(r + 16);

    // Reload ch0 to 2 while its count is 1: old period completes first
    c0 = cyc;
    for (int c = c0; c <= c0 + 12; c++) begin
      ce[0] = (c == c0 + 4) || (c >= c0 + 6 && ((c - (c0 + 6)) % 2 == 0));
      ce[1] = ((c - r) % 3 == 0);
      push(c, ce, 1'b0, 1'b1);
    end
    i_div = {8'd3, 8'd2}; i_div_load = 1'b1;
    wait_cyc(cyc + 1);
    i_div_load = 1'b0;
    wait_cyc(c0 + 13);

    m = cyc; i_lock = 1'b0;
    push_idle(m + 3, m + 4);
    wait_cyc(m + 5);
    check("loss_two", 32'(o_loss_cnt), 2);

    // Disabled ch1, plus a lock dropout during SETTLE that re-times release
    i_div = {8'd0, 8'd4}; i_div_load = 1'b1;
    wait_cyc(cyc + 1);
    i_div_load = 1'b0;
    wait_cyc(cyc + 2);
    n = cyc; i_lock = 1'b1;
    push_idle(n + 1, n + 19);
    push_run(n + 20, 12, n + 20, 4, 0);
    wait_cyc(n + 5); i_lock = 1'b0;
    wait_cyc(n + 9); i_lock = 1'b1;
    wait_cyc(n + 32);
    check("loss_settle", 32'(o_loss_cnt), 2);

    // Asynchronous reset mid-RUN
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("arst_o_rst", 32'(o_rst), 1);
    check("arst_ready", 32'(o_ready), 0);
    check("arst_ce", 32'(o_ce), 0);
    check("arst_loss", 32'(o_loss_cnt), 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    n = cyc;
    push_idle(n + 1, n + 10);
    push_run(n + 11, 3, n + 11, 1, 1);
    wait_cyc(n + 14);

    // Repeated lock loss saturates the counter
    for (int k = 1; k <= 300; k++) begin
      i_lock = 1'b0;
      wait_cyc(cyc + 4);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        check($sformatf("loss_sat_%0d", k), 32'(o_loss_cnt), (k > 255) ? 255 : k);
      i_lock = 1'b1;
      wait_cyc(cyc + 12);
    end

    wait_cyc(cyc + 2);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hclk_seq.md
Name: hclk_seq

Overview:
Clock-domain supervisor for the fabric's fast (serial) clock domain. It watches the asynchronous PLL lock, sequences a synchronous domain reset, and generates up to CHANNELS phase-aligned, runtime-programmable clock-enable pulses. It replaces fixed hard-divider derived clocks, such as a fixed pixel clock of sclk/5, with single-clock enables. It sits directly after the PLL and feeds the reset and enables of all downstream logic in that domain.

Parameters:
CHANNELS, 2, number of independent clock-enable outputs (1..8)
DIV_W, 8, width of each channel divisor
SETTLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
CNT_W, 8, width of saturating lock-loss counter

Ports:
i_clk  in  1  domain clock (PLL output)
i_rst  in  1  asynchronous, active-high reset
i_lock  in  1  raw PLL lock, asynchronous to i_clk
i_div  in  CHANNELS*DIV_W  per-channel divisor, channel k at [k*DIV_W +: DIV_W]
i_div_load  in  1  one-cycle strobe; captures i_div into the shadow register
o_rst  out  1  synchronous domain reset, active-high
o_ready  out  1  domain running
o_ce  out  CHANNELS  per-channel clock-enable pulse
o_loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN

Behaviour:
- Reset is asynchronous and active-high (i_rst): all state clears immediately.
  - Reset values: o_rst=1, o_ready=0, o_ce=0, o_loss_cnt=0, shadow divisors=1, active divisors=1, FSM=WAIT_LOCK.
- i_lock passes through a 2-FF synchroniser (lock_s) cleared by i_rst. Latency is 2 cycles.
- FSM states:
  - WAIT_LOCK: o_rst=1. Go to SETTLE when lock_s=1; clear the settle counter.
  - SETTLE: the counter increments each cycle while lock_s=1. If lock_s=0, return to WAIT_LOCK (no loss count). When the counter reaches SETTLE_CYCLES-1 with lock_s=1, go to RUN.
  - RUN: o_rst=0, o_ready=1, registered, effective from the first RUN cycle. If lock_s=0, go to WAIT_LOCK on the next edge: o_rst=1, o_ready=0, o_ce=0 from that edge, and o_loss_cnt increments, saturating at all-ones.
- From the first lock_s=1 cycle, o_rst deasserts exactly SETTLE_CYCLES+1 cycles later (WAIT_LOCK→SETTLE edge plus SETTLE_CYCLES).
- Channel dividers:
  - Each channel k has cnt_k over 0..div_k-1. All cnt_k are forced to 0 on every entry to RUN, which phase-aligns the channels.
  - o_ce[k]=1 iff FSM=RUN, div_k!=0 and cnt_k==0. The output is combinational from registered state, so there is no extra latency.
  - The first pulse falls in the first RUN cycle on every enabled channel.
  - cnt_k increments each RUN cycle and wraps to 0 after div_k-1.
  - div_k=1 gives o_ce[k] high every RUN cycle. div_k=0 disables the channel (o_ce[k]=0, cnt held at 0).
- Divisor update:
  - i_div_load captures i_div into the shadow register.
  - Outside RUN, the shadow copies to the active register on the next cycle.
  - In RUN, channel k copies shadow_k to active_k only on its wrap cycle (cnt_k==div_k-1), or immediately if active div_k==0. There is never a truncated or stretched period.
  - If a load and a wrap occur in the same cycle, the wrap uses the old shadow and the new value applies at the following wrap.
  - Changing 0→N in RUN starts the channel with cnt=0 on the next cycle, so it is not aligned to the other channels.
- Lock glitch shorter than 2 cycles: it may be filtered by the synchroniser. No other behaviour is required.
- i_rst asserted mid-RUN: immediate return to the reset values; o_loss_cnt is also cleared.
- Width rules: the settle counter is $clog2(SETTLE_CYCLES+1) bits. Divider counters are DIV_W bits with no overflow, because cnt < div ≤ 2^DIV_W-1.

Test Plan:
1. SETTLE_CYCLES=8, i_lock raised at cycle 10 → o_rst falls and o_ready rises at cycle 10+2+1+8=21 (±0). On the same cycle, o_ce=2'b11 with div={1,1} defaults.
2. div0=5, div1=3 loaded in WAIT_LOCK, then lock → in RUN, o_ce[0] pulses at RUN+0,5,10. o_ce[1] pulses at RUN+0,3,6,9. Both coincide at RUN+0 and RUN+15.
3. In RUN with div0=5, load div0=2 at cnt0=1 → pulses at t, t+5, then t+7, t+9 (new value applied at wrap, no short period).
4. SETTLE_CYCLES=8, lock drops for 4 cycles during SETTLE → back to WAIT_LOCK, o_loss_cnt stays 0. The release is re-timed from the re-lock.
5. Lock drop in RUN → o_rst=1 and o_ce=0 three cycles after the raw drop, o_loss_cnt=1. Repeated 300 times with CNT_W=8 → o_loss_cnt saturates at 255.
6. div1=0 → o_ce[1] stays 0 through RUN. i_rst pulsed mid-RUN → all outputs return to reset values asynchronously, within the same cycle.
